// File: rtl/arb4_rr_merge_if.sv
// arb4_rr_merge_if: channel/output bundle for arb4_rr_merge; in_valid/in_data0..3/in_last/in_ready per channel, out_valid/out_data/out_src/out_last/out_ready stream; slave = merge stage, master = its environment
interface arb4_rr_merge_if #(parameter int DW = 8);
  logic [3:0] in_valid;
  logic [DW-1:0] in_data0;
  logic [DW-1:0] in_data1;
  logic [DW-1:0] in_data2;
  logic [DW-1:0] in_data3;
  logic [3:0] in_last;
  logic [3:0] in_ready;
  logic out_valid;
  logic [DW-1:0] out_data;
  logic [1:0] out_src;
  logic out_last;
  logic out_ready;
  modport slave (
    input in_valid, in_data0, in_data1, in_data2, in_data3, in_last, out_ready,
    output in_ready, out_valid, out_data, out_src, out_last
  );
  modport master (
    output in_valid, in_data0, in_data1, in_data2, in_data3, in_last, out_ready,
    input in_ready, out_valid, out_data, out_src, out_last
  );
endinterface

// File: rtl/arb4_rr_merge.sv
// arb4_rr_merge: 4-channel round-robin merge into one registered tagged stream; ports clk, rst (sync active-high), bus (arb4_rr_merge_if.slave: 4 valid/data/last/ready channels in, out_valid/data/src/last with out_ready); define ARB4_RR_MERGE_LOCK_EN to hold the grant until a packet's last beat
module arb4_rr_merge #(parameter int DW = 8) (
  input logic clk,
  input logic rst,
  arb4_rr_merge_if.slave bus
);
  logic [DW-1:0] w_data [4];
  logic [DW-1:0] r_data;
  logic [1:0] r_ptr, r_src, w_win, w_sel;
  logic r_valid, r_last, w_any, w_load_ok, w_xfer, w_ptr_upd;
  assign w_data[0] = bus.in_data0;
  assign w_data[1] = bus.in_data1;
  assign w_data[2] = bus.in_data2;
  assign w_data[3] = bus.in_data3;
  assign w_any = |bus.in_valid;
  assign w_load_ok = ~r_valid | bus.out_ready;
  always_comb begin
    w_win = r_ptr;
    for (int k = 3; k >= 0; k--)
      w_win = bus.in_valid[r_ptr + 2'(k)] ? r_ptr + 2'(k) : w_win;
  end
`ifdef ARB4_RR_MERGE_LOCK_EN
  logic r_locked;
  logic [1:0] r_lock_ch;
  assign w_sel = r_locked ? r_lock_ch : w_win;
  assign w_ptr_upd = bus.in_last[w_sel];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_locked <= 1'b0;
      r_lock_ch <= 2'd0;
    end else if (w_xfer) begin
      r_locked <= ~bus.in_last[w_sel];
      r_lock_ch <= w_sel;
    end
  end
`else
  assign w_sel = w_win;
  assign w_ptr_upd = 1'b1;
`endif
  assign bus.in_ready = (~rst & w_load_ok & w_any) ? 4'b0001 << w_sel : 4'b0000;
  assign w_xfer = |(bus.in_valid & bus.in_ready);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data <= '0;
      r_src <= 2'd0;
      r_last <= 1'b0;
      r_ptr <= 2'd0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data <= w_data[w_sel];
      r_src <= w_sel;
      r_last <= bus.in_last[w_sel];
      if (w_ptr_upd) r_ptr <= w_sel + 2'd1;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end
  assign bus.out_valid = r_valid;
  assign bus.out_data = r_data;
  assign bus.out_src = r_src;
  assign bus.out_last = r_last;
endmodule

// File: tb/tb_arb4_rr_merge.sv
// tb_arb4_rr_merge: directed plus randomized checks of arb4_rr_merge against a cycle-level reference model
module tb_arb4_rr_merge;
  logic clk, rst;
  int n_vec, n_err;
  arb4_rr_merge_if #(.DW(8)) b();
  arb4_rr_merge #(.DW(8)) dut (.clk(clk), .rst(rst), .bus(b));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int m_ptr, m_src, m_lock_ch;
  bit m_valid, m_last, m_locked;
  logic [7:0] m_data;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] din(input int i);
    return i == 0 ? b.in_data0 : i == 1 ? b.in_data1 : i == 2 ? b.in_data2 : b.in_data3;
  endfunction
  task automatic cycle();
    int w, n_ptr, n_src, n_lock_ch;
    bit found, n_valid, n_last, n_locked;
    logic [7:0] n_data;
    logic [3:0] er;
    @(negedge clk);
    w = 0;
    found = 0;
    for (int off = 0; off < 4; off++)
      if (!found && b.in_valid[(m_ptr + off) % 4]) begin
        w = (m_ptr + off) % 4;
        found = 1;
      end
    if (m_locked) w = m_lock_ch;
    er = (rst || !found || !(!m_valid || b.out_ready)) ? 4'b0000 : 4'(1 << w);
    chk("in_ready", b.in_ready, er);
    chk("out_valid", b.out_valid, m_valid);
    chk("out_data", b.out_data, m_data);
    chk("out_src", b.out_src, m_src);
    chk("out_last", b.out_last, m_last);
    {n_valid, n_data, n_src, n_last, n_ptr, n_locked, n_lock_ch} = {m_valid, m_data, m_src, m_last, m_ptr, m_locked, m_lock_ch};
    if (rst) begin
      {n_valid, n_data, n_src, n_last, n_ptr, n_locked, n_lock_ch} = '0;
    end else if ((er & b.in_valid) != 0) begin
      n_valid = 1;
      n_data = din(w);
      n_src = w;
      n_last = b.in_last[w];
`ifdef ARB4_RR_MERGE_LOCK_EN
      n_locked = !b.in_last[w];
      n_lock_ch = w;
      if (b.in_last[w]) n_ptr = (w + 1) % 4;
`else
      n_ptr = (w + 1) % 4;
`endif
    end else if (b.out_ready) begin
      n_valid = 0;
    end
    @(posedge clk);
    #1;
    {m_valid, m_data, m_src, m_last, m_ptr, m_locked, m_lock_ch} = {n_valid, n_data, n_src, n_last, n_ptr, n_locked, n_lock_ch};
  endtask
  initial begin
    int exp_src[6] = '{0, 1, 2, 3, 0, 1};
    int exp6[4];
    n_vec = 0;
    n_err = 0;
    {m_valid, m_data, m_src, m_last, m_ptr, m_locked, m_lock_ch} = '0;
    rst = 1;
    b.in_valid = 4'b1111;
    b.in_last = 4'b0000;
    b.out_ready = 1;
    b.in_data0 = 8'hA0;
    b.in_data1 = 8'hA1;
    b.in_data2 = 8'hA2;
    b.in_data3 = 8'hA3;
    @(posedge clk);
    #1;
    repeat (2) begin
      cycle();
      chk("rst_ready", b.in_ready, 4'b0000);
      chk("rst_valid", b.out_valid, 0);
      chk("rst_src", b.out_src, 0);
      chk("rst_data", b.out_data, 0);
    end
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rot_valid", b.out_valid, 1);
      chk("rot_src", b.out_src, exp_src[i]);
      chk("rot_data", b.out_data, 8'hA0 + exp_src[i]);
    end
    b.in_valid = 4'b0100;
    b.in_data2 = 8'h5C;
    cycle();
    chk("bp_load", b.out_src, 2);
    b.out_ready = 0;
    b.in_valid = 4'b1111;
    repeat (4) begin
      cycle();
      chk("bp_valid", b.out_valid, 1);
      chk("bp_data", b.out_data, 8'h5C);
      chk("bp_src", b.out_src, 2);
      chk("bp_ready", b.in_ready, 4'b0000);
    end
    b.out_ready = 1;
    cycle();
    chk("bp_next", b.out_src, 3);
    b.in_valid = 4'b0100;
    cycle();
    b.in_valid = 4'b0101;
    cycle();
    chk("wrap_src", b.out_src, 0);
    cycle();
    chk("skip_src", b.out_src, 2);
    b.in_valid = 4'b0010;
    b.in_data1 = 8'h11;
    cycle();
    chk("sparse_valid", b.out_valid, 1);
    chk("sparse_src", b.out_src, 1);
    chk("sparse_data", b.out_data, 8'h11);
    b.in_valid = 4'b0000;
    cycle();
    chk("sparse_drain", b.out_valid, 0);
    rst = 1;
    cycle();
    rst = 0;
    b.in_valid = 4'b0001;
    cycle();
    b.in_valid = 4'b1111;
`ifdef ARB4_RR_MERGE_LOCK_EN
    exp6 = '{1, 1, 1, 2};
`else
    exp6 = '{1, 2, 3, 0};
`endif
    for (int k = 0; k < 4; k++) begin
      b.in_last = (k == 2) ? 4'b0010 : 4'b0000;
      cycle();
      chk("lock_src", b.out_src, exp6[k]);
    end
    b.in_last = 4'b0000;
    b.in_valid = 4'b1011;
    cycle();
`ifdef ARB4_RR_MERGE_LOCK_EN
    chk("lock_idle", b.out_valid, 0);
`else
    chk("nolock_idle", b.out_src, 1);
`endif
    repeat (500) begin
      rst = ($urandom_range(0, 39) == 0);
      b.in_valid = 4'($urandom);
      b.in_last = 4'($urandom);
      b.in_data0 = 8'($urandom);
      b.in_data1 = 8'($urandom);
      b.in_data2 = 8'($urandom);
      b.in_data3 = 8'($urandom);
      b.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
